seq_multiplier: RTL and testbench

SEQ_MULTIPLIER -- requirements
Module: seq_multiplier

---
 rtl/seq_multiplier.sv | 133 +++++++++++++
 tb/tb_seq_multiplier.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/seq_multiplier.sv
// seq_multiplier: sequential shift-add multiplier, one partial product per clock.
// A multiply takes exactly WIDTH clocks in CALC. The product lands in p together
// with a one-cycle done pulse. A start seen in DONE begins the next multiply
// straight away, with no IDLE cycle in between.
//
// Optional build macro: SIGNED_MULT_EN
//   defined   -> a and b are two's complement. The operand magnitudes are
//                multiplied, and the result is negated when the signs differ.
//   undefined -> a and b are unsigned and no sign logic is built.
//
// Ports:
//   clk    in   1        rising-edge clock
//   rst    in   1        synchronous active-high reset
//   start  in   1        begin a multiply; ignored while busy
//   a      in   WIDTH    multiplicand, captured on acceptance
//   b      in   WIDTH    multiplier, captured on acceptance
//   busy   out  1        high while in CALC
//   done   out  1        one-cycle pulse when p takes a new result
//   p      out  2*WIDTH  last product, held until the next one completes
module seq_multiplier #(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] p
);

  localparam int unsigned PW    = 2 * WIDTH;
  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e           state_q;
  logic [PW-1:0]    acc_q;
  logic [PW-1:0]    mcand_q;
  logic [WIDTH-1:0] mplier_q;
  logic [CNT_W-1:0] cnt_q;

  logic [WIDTH-1:0] a_op_d;
  logic [WIDTH-1:0] b_op_d;
  logic [PW-1:0]    acc_d;
  logic [PW-1:0]    p_d;

`ifdef SIGNED_MULT_EN
  logic neg_q;
  logic neg_d;

  // Operand magnitudes. -2^(W-1) maps to 2^(W-1), which still fits in W unsigned bits.
  always_comb begin
    a_op_d = a[WIDTH-1] ? WIDTH'(~a + WIDTH'(1)) : a;
    b_op_d = b[WIDTH-1] ? WIDTH'(~b + WIDTH'(1)) : b;
    neg_d  = a[WIDTH-1] ^ b[WIDTH-1];
  end
`else
  always_comb begin
    a_op_d = a;
    b_op_d = b;
  end
`endif

  // One shift-add step, plus sign correction of the final sum.
  always_comb begin
    acc_d = acc_q + (mplier_q[0] ? mcand_q : '0);
`ifdef SIGNED_MULT_EN
    p_d   = neg_q ? PW'(~acc_d + PW'(1)) : acc_d;
`else
    p_d   = acc_d;
`endif
  end

  // Control FSM and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      p        <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
`ifdef SIGNED_MULT_EN
      neg_q    <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            acc_q    <= '0;
            mcand_q  <= PW'(a_op_d);
            mplier_q <= b_op_d;
            cnt_q    <= '0;
`ifdef SIGNED_MULT_EN
            neg_q    <= neg_d;
`endif
            busy     <= 1'b1;
            state_q  <= S_CALC;
          end else begin
            state_q  <= S_IDLE;
          end
        end
        S_CALC: begin
          acc_q    <= acc_d;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + CNT_W'(1);
          if (cnt_q == LAST_ITER) begin
            p       <= p_d;
            done    <= 1'b1;
            busy    <= 1'b0;
            state_q <= S_DONE;
          end
        end
        default: begin
          busy    <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_multiplier.sv
// Scoreboard bench for seq_multiplier (WIDTH=8 main instance, WIDTH=2 corner instance).
module tb_seq_multiplier;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  a, b;
  logic        busy, done;
  logic [15:0] p;

  logic        start2;
  logic [1:0]  a2, b2;
  logic        busy2, done2;
  logic [3:0]  p2;

  int n_checks = 0;
  int n_errors = 0;
  int n_done   = 0;
  logic [15:0] sb_q[$];

  seq_multiplier #(.WIDTH(8)) u_dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .p(p)
  );

  seq_multiplier #(.WIDTH(2)) u_dut2 (
    .clk(clk), .rst(rst), .start(start2), .a(a2), .b(b2),
    .busy(busy2), .done(done2), .p(p2)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] model(input logic [7:0] x, input logic [7:0] y);
`ifdef SIGNED_MULT_EN
    return 16'($signed(x)) * 16'($signed(y));
`else
    return 16'(x) * 16'(y);
`endif
  endfunction

  function automatic logic [3:0] model2(input logic [1:0] x, input logic [1:0] y);
`ifdef SIGNED_MULT_EN
    return 4'($signed(x)) * 4'($signed(y));
`else
    return 4'(x) * 4'(y);
`endif
  endfunction

  // Every done pulse must match the oldest outstanding expected product.
  always @(negedge clk) begin
    if (done) begin
      n_done++;
      if (sb_q.size() == 0) check("unexpected_done", 32'd1, 32'd0);
      else                  check("product", 32'(p), 32'(sb_q.pop_front()));
    end
  end

  // Called at the first negedge after acceptance; checks latency, busy span and pulse width.
  task automatic wait_done(input string tag, input logic exp_busy_after);
    int cyc;
    int nb;
    cyc = 0;
    nb  = 0;
    while (!done && cyc < 40) begin
      if (busy) nb++;
      cyc++;
      @(negedge clk);
    end
    check({tag, "_latency"}, 32'(cyc), 32'd8);
    check({tag, "_busy_cycles"}, 32'(nb), 32'd8);
    @(negedge clk);
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
    check({tag, "_busy_after"}, 32'(busy), 32'(exp_busy_after));
  endtask

  task automatic run_op(input logic [7:0] ta, input logic [7:0] tbv, input string tag);
    @(negedge clk);
    start = 1'b1;
    a     = ta;
    b     = tbv;
    sb_q.push_back(model(ta, tbv));
    @(negedge clk);
    start = 1'b0;
    a     = 8'($urandom);
    b     = 8'($urandom);
    wait_done(tag, 1'b0);
    check({tag, "_p_hold"}, 32'(p), 32'(model(ta, tbv)));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int cyc;
    int n0;
    rst    = 1'b1;
    start  = 1'b0;
    a      = '0;
    b      = '0;
    start2 = 1'b0;
    a2     = '0;
    b2     = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_p", 32'(p), 32'd0);
    check("reset_p2", 32'(p2), 32'd0);

    // Reset wins over a simultaneous start.
    start = 1'b1;
    a     = 8'd7;
    b     = 8'd9;
    @(negedge clk);
    check("rst_prio_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    sb_q.push_back(model(8'd7, 8'd9));
    @(negedge clk);
    check("first_edge_accept", 32'(busy), 32'd1);
    start = 1'b0;
    wait_done("rst_release", 1'b0);

    run_op(8'd255, 8'd255, "max");
    run_op(8'h80, 8'h80, "most_neg");
    run_op(8'hFF, 8'hFF, "all_ones");
    run_op(8'hFD, 8'd5, "mixed_sign");
    for (int i = 0; i < 4; i++) run_op(8'($urandom), 8'($urandom), "random");

    // Back-to-back: start held high through CALC and DONE.
    @(negedge clk);
    start = 1'b1;
    a     = 8'd0;
    b     = 8'd200;
    sb_q.push_back(model(8'd0, 8'd200));
    @(negedge clk);
    a = 8'd12;
    b = 8'd11;
    sb_q.push_back(model(8'd12, 8'd11));
    wait_done("b2b_first", 1'b1);
    start = 1'b0;
    a     = 8'd1;
    b     = 8'd1;
    wait_done("b2b_second", 1'b0);
    check("b2b_p", 32'(p), 32'(model(8'd12, 8'd11)));

    // start pulses and operand churn during CALC must not disturb the operation.
    n0 = n_done;
    @(negedge clk);
    start = 1'b1;
    a     = 8'h5A;
    b     = 8'h3C;
    sb_q.push_back(model(8'h5A, 8'h3C));
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      start = 1'(i % 2);
      a     = 8'($urandom);
      b     = 8'($urandom);
    end
    start = 1'b0;
    repeat (14) @(negedge clk);
    check("churn_one_done", 32'(n_done - n0), 32'd1);
    check("churn_p", 32'(p), 32'(model(8'h5A, 8'h3C)));

    // Reset at the 4th CALC cycle aborts the operation.
    @(negedge clk);
    start = 1'b1;
    a     = 8'd100;
    b     = 8'd3;
    sb_q.push_back(model(8'd100, 8'd3));
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_p", 32'(p), 32'd0);
    rst = 1'b0;
    sb_q.delete();
    n0 = n_done;
    repeat (12) @(negedge clk);
    check("abort_no_done", 32'(n_done - n0), 32'd0);
    check("abort_p_stays", 32'(p), 32'd0);
    run_op(8'd100, 8'd3, "after_abort");

    // WIDTH=2 instance: 2x1 then 3x3.
    @(negedge clk);
    start2 = 1'b1;
    a2     = 2'd2;
    b2     = 2'd1;
    @(negedge clk);
    start2 = 1'b0;
    a2     = 2'd0;
    cyc    = 0;
    while (!done2 && cyc < 20) begin
      cyc++;
      @(negedge clk);
    end
    check("w2_latency", 32'(cyc), 32'd2);
    check("w2_p_2x1", 32'(p2), 32'(model2(2'd2, 2'd1)));
    @(negedge clk);
    check("w2_done_pulse", 32'(done2), 32'd0);
    start2 = 1'b1;
    a2     = 2'd3;
    b2     = 2'd3;
    @(negedge clk);
    start2 = 1'b0;
    b2     = 2'd0;
    cyc    = 0;
    while (!done2 && cyc < 20) begin
      cyc++;
      @(negedge clk);
    end
    check("w2_latency_b", 32'(cyc), 32'd2);
    check("w2_p_3x3", 32'(p2), 32'(model2(2'd3, 2'd3)));

    repeat (5) @(negedge clk);
    check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
